// File: rtl/regional_bus_master_pkg.sv
// Shared definitions for the regional bus initiator and its peers.
// Holds the FSM encoding, bus widths, the default region tag, the command and
// response payload structs and the region decode helper.
package regional_bus_master_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned TAG_W  = 4;

  localparam logic [TAG_W-1:0] REGION_TAG_DEFAULT = 4'h1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RSP  = 2'd2
  } state_e;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } cmd_t;

  typedef struct packed {
    logic              err;
    logic [DATA_W-1:0] rdata;
  } rsp_t;

  // Region is selected by the top nibble of the byte address.
  function automatic logic in_region(input logic [ADDR_W-1:0] addr,
                                     input logic [TAG_W-1:0]  tag);
    return addr[ADDR_W-1 -: TAG_W] == tag;
  endfunction

endpackage

// File: rtl/regional_bus_master_if.sv
// Regional peripheral bus (req/we/addr/data/ack).
// master: drives req_o, we_o, addr_o, data_o; samples data_i, ack_i.
// slave : the regional decoder side, opposite directions.
interface regional_bus_master_if;
  import regional_bus_master_pkg::*;

  logic              req_o;
  logic              we_o;
  logic [ADDR_W-1:0] addr_o;
  logic [DATA_W-1:0] data_o;
  logic [DATA_W-1:0] data_i;
  logic              ack_i;

  modport master (
    output req_o, we_o, addr_o, data_o,
    input  data_i, ack_i
  );

  modport slave (
    input  req_o, we_o, addr_o, data_o,
    output data_i, ack_i
  );

endinterface

// File: rtl/regional_bus_master_timeout_cnt.sv
// bus_timeout_cnt: clear/enable/expire counter for bus access timeouts.
// Ports: clk, rst (async, active high), clr_i (sync clear), en_i (count one
// waiting cycle), expire_c (combinational: enabled cycle TIMEOUT-1 reached).
module bus_timeout_cnt #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CNT_W   = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_c
);

  logic [CNT_W-1:0] cnt_q;

  // Counts waiting cycles; value k means k cycles have already gone unanswered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (en_i) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // Expires on the TIMEOUT-th unanswered cycle, so the requester waits exactly TIMEOUT cycles.
  assign expire_c = en_i && (cnt_q == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/regional_bus_master.sv
// regional_bus_master: initiator end of the regional peripheral bus.
// Accepts one core command at a time (cmd_valid_i/cmd_ready_o), issues it on the
// bus (req held until ack), and returns read data or an error response
// (rsp_valid_o/rsp_ready_i). Errors: access timeout, or address outside the region.
// Ports: clk, rst (async active high); cmd_*; rsp_*; bus (master modport);
// err_cnt_o saturating count of error responses.
module regional_bus_master
  import regional_bus_master_pkg::*;
#(
  parameter int unsigned      TIMEOUT    = 255,
  parameter logic [TAG_W-1:0] REGION_TAG = REGION_TAG_DEFAULT,
  parameter int unsigned      CNT_W      = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cmd_valid_i,
  output logic                       cmd_ready_o,
  input  logic                       cmd_we_i,
  input  logic [ADDR_W-1:0]          cmd_addr_i,
  input  logic [DATA_W-1:0]          cmd_wdata_i,
  output logic                       rsp_valid_o,
  input  logic                       rsp_ready_i,
  output logic [DATA_W-1:0]          rsp_rdata_o,
  output logic                       rsp_err_o,
  regional_bus_master_if.master      bus,
  output logic [CNT_W-1:0]           err_cnt_o
);

  // Reject parameter sets the timeout counter cannot represent.
  if (TIMEOUT < 2 || TIMEOUT > 65535 || TIMEOUT > (2 ** CNT_W)) begin : g_bad_timeout
    $error("regional_bus_master: TIMEOUT out of range for CNT_W");
  end

  state_e           state_q, state_d;
  cmd_t             cmd_q, cmd_d;
  rsp_t             rsp_q, rsp_d;
  logic             req_q, req_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic             cmd_ready_q, cmd_ready_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic             expire_c;
  logic             to_en_c;
  logic             to_clr_c;

  // Only unanswered request cycles advance the timeout.
  assign to_en_c  = (state_q == ST_REQ) && !bus.ack_i;
  assign to_clr_c = (state_q != ST_REQ);

  bus_timeout_cnt #(
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) u_timeout (
    .clk      (clk),
    .rst      (rst),
    .clr_i    (to_clr_c),
    .en_i     (to_en_c),
    .expire_c (expire_c)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; ack takes priority over an expiring timeout.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (cmd_valid_i) begin
          state_d = in_region(cmd_addr_i, REGION_TAG) ? ST_REQ : ST_RSP;
        end
      end
      ST_REQ: begin
        if (bus.ack_i || expire_c) begin
          state_d = ST_RSP;
        end
      end
      ST_RSP: begin
        if (rsp_ready_i) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output / datapath next values, registered below.
  always_comb begin
    cmd_d       = cmd_q;
    rsp_d       = rsp_q;
    err_cnt_d   = err_cnt_q;
    req_d       = (state_d == ST_REQ);
    rsp_valid_d = (state_d == ST_RSP);
    cmd_ready_d = (state_d == ST_IDLE);
    unique case (state_q)
      ST_IDLE: begin
        if (cmd_valid_i) begin
          cmd_d = '{we: cmd_we_i, addr: cmd_addr_i, wdata: cmd_wdata_i};
          if (!in_region(cmd_addr_i, REGION_TAG)) begin
            rsp_d = '{err: 1'b1, rdata: '0};
            if (err_cnt_q != '1) err_cnt_d = err_cnt_q + CNT_W'(1);
          end
        end
      end
      ST_REQ: begin
        if (bus.ack_i) begin
          rsp_d = '{err: 1'b0, rdata: (cmd_q.we ? '0 : bus.data_i)};
        end else if (expire_c) begin
          rsp_d = '{err: 1'b1, rdata: '0};
          if (err_cnt_q != '1) err_cnt_d = err_cnt_q + CNT_W'(1);
        end
      end
      ST_RSP: begin
        if (rsp_ready_i) begin
          rsp_d = '0;
        end
      end
      default: ;
    endcase
  end

  // Output and datapath registers; reset drops req/rsp_valid immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd_q       <= '0;
      rsp_q       <= '0;
      req_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      cmd_ready_q <= 1'b1;
      err_cnt_q   <= '0;
    end else begin
      cmd_q       <= cmd_d;
      rsp_q       <= rsp_d;
      req_q       <= req_d;
      rsp_valid_q <= rsp_valid_d;
      cmd_ready_q <= cmd_ready_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign cmd_ready_o = cmd_ready_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_rdata_o = rsp_q.rdata;
  assign rsp_err_o   = rsp_q.err;
  assign err_cnt_o   = err_cnt_q;
  assign bus.req_o   = req_q;
  assign bus.we_o    = cmd_q.we;
  assign bus.addr_o  = cmd_q.addr;
  assign bus.data_o  = cmd_q.wdata;

endmodule

// File: tb/tb_regional_bus_master.sv
module tb_regional_bus_master;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // DUT A: TIMEOUT=8, CNT_W=8
  logic        cmd_valid = 1'b0, cmd_we = 1'b0, rsp_ready = 1'b1;
  logic [31:0] cmd_addr = '0, cmd_wdata = '0;
  logic        cmd_ready, rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic [7:0]  err_cnt;
  logic        ack_auto = 1'b0, ack_force = 1'b0;
  logic [31:0] bus_rdata = '0;

  regional_bus_master_if bus_a ();
  assign bus_a.ack_i  = ack_auto ? bus_a.req_o : ack_force;
  assign bus_a.data_i = bus_rdata;

  regional_bus_master #(.TIMEOUT(8), .REGION_TAG(4'h1), .CNT_W(8)) dut_a (
    .clk(clk), .rst(rst),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_we_i(cmd_we),
    .cmd_addr_i(cmd_addr), .cmd_wdata_i(cmd_wdata),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
    .rsp_rdata_o(rsp_rdata), .rsp_err_o(rsp_err),
    .bus(bus_a), .err_cnt_o(err_cnt)
  );

  // DUT B: CNT_W=2 for saturation
  logic        b_cmd_valid = 1'b0;
  logic [31:0] b_cmd_addr = '0;
  logic        b_cmd_ready, b_rsp_valid, b_rsp_err;
  logic [31:0] b_rsp_rdata;
  logic [1:0]  b_err_cnt;

  regional_bus_master_if bus_b ();
  assign bus_b.ack_i  = 1'b0;
  assign bus_b.data_i = 32'h0;

  regional_bus_master #(.TIMEOUT(4), .REGION_TAG(4'h1), .CNT_W(2)) dut_b (
    .clk(clk), .rst(rst),
    .cmd_valid_i(b_cmd_valid), .cmd_ready_o(b_cmd_ready), .cmd_we_i(1'b0),
    .cmd_addr_i(b_cmd_addr), .cmd_wdata_i(32'h0),
    .rsp_valid_o(b_rsp_valid), .rsp_ready_i(1'b1),
    .rsp_rdata_o(b_rsp_rdata), .rsp_err_o(b_rsp_err),
    .bus(bus_b), .err_cnt_o(b_err_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Inputs are driven and outputs sampled on the falling edge.
  task automatic cyc();
    @(negedge clk);
  endtask

  initial begin
    cyc(); cyc();
    rst = 1'b0;
    cyc();
    // Reset state
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_req", 32'(bus_a.req_o), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_err_cnt", 32'(err_cnt), 32'd0);
    chk("rst_rdata", rsp_rdata, 32'd0);

    // ack outside REQ is ignored
    ack_force = 1'b1;
    cyc();
    chk("idle_ack_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("idle_ack_cmd_ready", 32'(cmd_ready), 32'd1);
    ack_force = 1'b0;

    // Read, zero-wait ack
    ack_auto = 1'b1; bus_rdata = 32'hCAFE_0001;
    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = 32'h1000_0010;
    cyc();
    cmd_valid = 1'b0;
    chk("rd_req_n1", 32'(bus_a.req_o), 32'd1);
    chk("rd_addr", bus_a.addr_o, 32'h1000_0010);
    chk("rd_we", 32'(bus_a.we_o), 32'd0);
    chk("rd_cmd_ready_busy", 32'(cmd_ready), 32'd0);
    cyc();
    chk("rd_req_n2", 32'(bus_a.req_o), 32'd0);
    chk("rd_rsp_valid_n2", 32'(rsp_valid), 32'd1);
    chk("rd_rdata", rsp_rdata, 32'hCAFE_0001);
    chk("rd_err", 32'(rsp_err), 32'd0);
    cyc();
    chk("rd_done_valid", 32'(rsp_valid), 32'd0);
    chk("rd_done_ready", 32'(cmd_ready), 32'd1);

    // Write, ack after 3 wait cycles
    ack_auto = 1'b0; bus_rdata = 32'hDEAD_BEEF;
    cmd_valid = 1'b1; cmd_we = 1'b1; cmd_addr = 32'h1000_0020; cmd_wdata = 32'h1234_5678;
    cyc();
    cmd_valid = 1'b0; cmd_addr = 32'h0; cmd_wdata = 32'h0;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("wr_req_%0d", i), 32'(bus_a.req_o), 32'd1);
      chk($sformatf("wr_addr_%0d", i), bus_a.addr_o, 32'h1000_0020);
      chk($sformatf("wr_data_%0d", i), bus_a.data_o, 32'h1234_5678);
      chk($sformatf("wr_we_%0d", i), 32'(bus_a.we_o), 32'd1);
      if (i == 3) ack_force = 1'b1;
      cyc();
    end
    ack_force = 1'b0;
    chk("wr_req_off", 32'(bus_a.req_o), 32'd0);
    chk("wr_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("wr_rdata", rsp_rdata, 32'd0);
    chk("wr_err", 32'(rsp_err), 32'd0);
    cyc();

    // Read timeout after exactly 8 request cycles
    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = 32'h1000_0030;
    cyc();
    cmd_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("to_req_%0d", i), 32'(bus_a.req_o), 32'd1);
      chk($sformatf("to_valid_%0d", i), 32'(rsp_valid), 32'd0);
      cyc();
    end
    chk("to_req_off", 32'(bus_a.req_o), 32'd0);
    chk("to_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("to_err", 32'(rsp_err), 32'd1);
    chk("to_rdata", rsp_rdata, 32'd0);
    chk("to_err_cnt", 32'(err_cnt), 32'd1);
    cyc();

    // Out-of-region command, response held by rsp_ready low for 5 cycles
    rsp_ready = 1'b0;
    cmd_valid = 1'b1; cmd_addr = 32'h2000_0000;
    cyc();
    chk("oor_req", 32'(bus_a.req_o), 32'd0);
    chk("oor_rsp_valid_n1", 32'(rsp_valid), 32'd1);
    chk("oor_err", 32'(rsp_err), 32'd1);
    chk("oor_rdata", rsp_rdata, 32'd0);
    chk("oor_err_cnt", 32'(err_cnt), 32'd2);
    // Next command presented during the hold must wait for the handshake
    ack_auto = 1'b1; bus_rdata = 32'h0000_00A5; cmd_addr = 32'h1000_0040;
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk($sformatf("hold_valid_%0d", i), 32'(rsp_valid), 32'd1);
      chk($sformatf("hold_err_%0d", i), 32'(rsp_err), 32'd1);
      chk($sformatf("hold_ready_%0d", i), 32'(cmd_ready), 32'd0);
      chk($sformatf("hold_req_%0d", i), 32'(bus_a.req_o), 32'd0);
    end
    rsp_ready = 1'b1;
    cyc();
    chk("hold_rel_valid", 32'(rsp_valid), 32'd0);
    chk("hold_rel_ready", 32'(cmd_ready), 32'd1);
    chk("hold_rel_req", 32'(bus_a.req_o), 32'd0);
    cyc();
    cmd_valid = 1'b0;
    chk("next_req", 32'(bus_a.req_o), 32'd1);
    chk("next_addr", bus_a.addr_o, 32'h1000_0040);
    cyc();
    chk("next_rdata", rsp_rdata, 32'h0000_00A5);
    chk("next_err", 32'(rsp_err), 32'd0);
    chk("next_err_cnt", 32'(err_cnt), 32'd2);
    cyc();

    // Reset pulse in the middle of a request
    ack_auto = 1'b0;
    cmd_valid = 1'b1; cmd_addr = 32'h1000_0050;
    cyc();
    cmd_valid = 1'b0;
    cyc();
    chk("mid_req_before", 32'(bus_a.req_o), 32'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst_req", 32'(bus_a.req_o), 32'd0);
    chk("mid_rst_valid", 32'(rsp_valid), 32'd0);
    chk("mid_rst_ready", 32'(cmd_ready), 32'd1);
    chk("mid_rst_err_cnt", 32'(err_cnt), 32'd0);
    cyc();
    rst = 1'b0;
    cyc();
    chk("post_rst_ready", 32'(cmd_ready), 32'd1);
    ack_auto = 1'b1; bus_rdata = 32'h1357_9BDF;
    cmd_valid = 1'b1; cmd_addr = 32'h1000_0060;
    cyc();
    cmd_valid = 1'b0;
    chk("post_rst_req", 32'(bus_a.req_o), 32'd1);
    cyc();
    chk("post_rst_valid", 32'(rsp_valid), 32'd1);
    chk("post_rst_rdata", rsp_rdata, 32'h1357_9BDF);
    chk("post_rst_err", 32'(rsp_err), 32'd0);
    cyc();

    // Error counter saturation on the narrow instance: 5 out-of-region commands
    b_cmd_valid = 1'b1; b_cmd_addr = 32'h3000_0000;
    for (int i = 0; i < 10; i++) begin
      cyc();
      chk($sformatf("sat_req_%0d", i), 32'(bus_b.req_o), 32'd0);
      if (i == 3) chk("sat_err_cnt_2", 32'(b_err_cnt), 32'd2);
    end
    b_cmd_valid = 1'b0;
    cyc();
    chk("sat_err_cnt", 32'(b_err_cnt), 32'd3);
    chk("sat_valid", 32'(b_rsp_valid), 32'd0);
    chk("sat_ready", 32'(b_cmd_ready), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
